// File: rtl/pc_ras_unit_pkg.sv
// Shared CPU datapath types for the PC and return-address-stack logic.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 26;
  localparam int RAS_DEPTH_DEF = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [$clog2(RAS_DEPTH_DEF)-1:0] ras_ptr_t;

  localparam word_t PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_BRANCH,
    NPC_JUMP,
    NPC_JR
  } npc_sel_e;

  // Pseudo-direct J/JAL target: keep the region bits of the sequential PC.
  function automatic word_t jump_target(input word_t pc4, input logic [ADDR_W-1:0] jimm);
    return {pc4[31:28], jimm, 2'b00};
  endfunction

  function automatic word_t branch_target(input word_t pc4, input word_t bimm);
    return pc4 + {bimm[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/pc_ras_unit_if.sv
// Fetch-side bus between the PC/RAS unit and the rest of the datapath.
interface pc_ras_if import cpu_types_pkg::*; #(
  parameter int CNT_W = 16
);

  logic              ihit;
  logic              stall;
  logic              Branch;
  word_t             bimm;
  logic              Jump;
  logic [ADDR_W-1:0] jimm;
  logic              JR;
  word_t             jraddr;
  logic              link;
  word_t             pcaddr;
  word_t             nxt_pc;
  word_t             ras_top;
  logic              ras_empty;
  logic              ras_miss;
  logic [CNT_W-1:0]  miss_cnt;

  modport pc (
    input  ihit, stall, Branch, bimm, Jump, jimm, JR, jraddr, link,
    output pcaddr, nxt_pc, ras_top, ras_empty, ras_miss, miss_cnt
  );

  modport tb (
    output ihit, stall, Branch, bimm, Jump, jimm, JR, jraddr, link,
    input  pcaddr, nxt_pc, ras_top, ras_empty, ras_miss, miss_cnt
  );

endinterface

// File: rtl/pc_ras_unit_ras_stack.sv
// Circular return-address stack: push on call, pop on return, replace on JALR.
module ras_stack import cpu_types_pkg::*; #(
  parameter int RAS_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  adv,
  input  logic  push,
  input  logic  pop,
  input  logic  repl,
  input  word_t wdata,
  output word_t top,
  output logic  empty
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_RW = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_RW-1:0] CNT_FULL = CNT_RW'(RAS_DEPTH);

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;
  logic [PTR_W-1:0]  wr_idx;
  logic [CNT_RW-1:0] count;
  logic              full;
  logic              wr_en;
  word_t             mem [RAS_DEPTH];

  // Depth is a power of two, so pointer arithmetic wraps for free.
  assign ptr_inc = ptr + PTR_W'(1);
  assign ptr_dec = ptr - PTR_W'(1);
  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign top     = empty ? '0 : mem[ptr];

  // A JALR on an empty stack behaves like a push; otherwise it rewrites the top slot.
  assign wr_en  = adv & (push | repl);
  assign wr_idx = (push | (repl & empty)) ? ptr_inc : ptr;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (adv) begin
      if (push) begin
        ptr <= ptr_inc;
        if (!full) begin
          count <= count + CNT_RW'(1);
        end
      end else if (pop && !empty) begin
        ptr   <= ptr_dec;
        count <= count - CNT_RW'(1);
      end else if (repl && empty) begin
        ptr   <= ptr_inc;
        count <= CNT_RW'(1);
      end
    end
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with next-PC selection, return-address stack and misprediction tracking.
module pc_ras_unit import cpu_types_pkg::*; #(
  parameter word_t PC_INIT   = 32'h0000_0000,
  parameter int    RAS_DEPTH = 4,
  parameter int    CNT_W     = 16
) (
  input logic CLK,
  input logic RST,
  pc_ras_if.pc bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             adv;
  word_t            pc_p0;
  word_t            pc4;
  word_t            nxt;
  npc_sel_e         sel;
  logic             push;
  logic             pop;
  logic             repl;
  word_t            top;
  logic             empty;
  logic             miss_now;
  logic             miss_p1;
  logic [CNT_W-1:0] cnt;

  assign adv = bus.ihit & ~bus.stall;
  assign pc4 = pc_p0 + PC_STEP;

  always_comb begin
    sel = NPC_SEQ;
    if (bus.JR) begin
      sel = NPC_JR;
    end else if (bus.Jump) begin
      sel = NPC_JUMP;
    end else if (bus.Branch) begin
      sel = NPC_BRANCH;
    end
  end

  always_comb begin
    nxt = pc4;
    case (sel)
      NPC_JR:     nxt = bus.jraddr;
      NPC_JUMP:   nxt = jump_target(pc4, bus.jimm);
      NPC_BRANCH: nxt = branch_target(pc4, bus.bimm);
      default:    nxt = pc4;
    endcase
  end

  assign push = bus.link & ~bus.JR;
  assign pop  = bus.JR & ~bus.link;
  assign repl = bus.JR & bus.link;

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH)
  ) u_stack (
    .clk   (CLK),
    .rst   (RST),
    .adv   (adv),
    .push  (push),
    .pop   (pop),
    .repl  (repl),
    .wdata (pc4),
    .top   (top),
    .empty (empty)
  );

  // Any return (plain JR or JALR) is checked against the current top; an empty stack always misses.
  assign miss_now = bus.JR & (empty | (top != bus.jraddr));

  // Stage p0 -> p1: PC register and registered miss/count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_p0 <= PC_INIT;
    end else if (adv) begin
      pc_p0 <= nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      miss_p1 <= 1'b0;
      cnt     <= '0;
    end else begin
      miss_p1 <= adv & miss_now;
      if (adv && miss_now && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pcaddr    = pc_p0;
  assign bus.nxt_pc    = nxt;
  assign bus.ras_top   = top;
  assign bus.ras_empty = empty;
  assign bus.ras_miss  = miss_p1;
  assign bus.miss_cnt  = cnt;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Bench for pc_ras_unit: directed scenarios plus random traffic against a queue-based model.
module tb_pc_ras_unit;
  import cpu_types_pkg::*;

  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  pc_ras_if #(.CNT_W(16)) bus_a ();
  pc_ras_if #(.CNT_W(2))  bus_b ();

  pc_ras_unit #(.PC_INIT(32'h0), .RAS_DEPTH(DEPTH), .CNT_W(16)) dut_a (
    .CLK (CLK), .RST (RST), .bus (bus_a.pc));
  pc_ras_unit #(.PC_INIT(32'h0), .RAS_DEPTH(DEPTH), .CNT_W(2)) dut_b (
    .CLK (CLK), .RST (RST), .bus (bus_b.pc));

  assign bus_b.ihit   = bus_a.ihit;
  assign bus_b.stall  = bus_a.stall;
  assign bus_b.Branch = bus_a.Branch;
  assign bus_b.bimm   = bus_a.bimm;
  assign bus_b.Jump   = bus_a.Jump;
  assign bus_b.jimm   = bus_a.jimm;
  assign bus_b.JR     = bus_a.JR;
  assign bus_b.jraddr = bus_a.jraddr;
  assign bus_b.link   = bus_a.link;

  int n_cmp = 0;
  int n_bad = 0;

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  word_t m_pc = 32'h0;
  word_t q[$];
  int    m_cnt_a = 0;
  int    m_cnt_b = 0;
  logic  m_miss = 1'b0;
  bit    chk_en = 1'b0;
  bit    t_miss;
  word_t t_pc4;
  word_t t_nxt;
  word_t t_pred;

  function word_t exp_nxt();
    word_t p4;
    p4 = m_pc + 32'd4;
    if (bus_a.JR)          return bus_a.jraddr;
    else if (bus_a.Jump)   return {p4[31:28], bus_a.jimm, 2'b00};
    else if (bus_a.Branch) return p4 + bus_a.bimm * 4;
    else                   return p4;
  endfunction

  function word_t exp_top();
    return (q.size() > 0) ? q[q.size()-1] : 32'h0;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_pc = 32'h0;
      q.delete();
      m_cnt_a = 0;
      m_cnt_b = 0;
      m_miss = 1'b0;
    end else begin
      t_miss = 1'b0;
      if (bus_a.ihit && !bus_a.stall) begin
        t_pc4 = m_pc + 32'd4;
        t_nxt = exp_nxt();
        if (bus_a.JR && !bus_a.link) begin
          if (q.size() == 0) t_miss = 1'b1;
          else begin
            t_pred = q.pop_back();
            t_miss = (t_pred != bus_a.jraddr);
          end
        end else if (bus_a.link && !bus_a.JR) begin
          q.push_back(t_pc4);
          if (q.size() > DEPTH) void'(q.pop_front());
        end else if (bus_a.JR && bus_a.link) begin
          if (q.size() == 0) begin
            t_miss = 1'b1;
            q.push_back(t_pc4);
          end else begin
            t_miss = (q[q.size()-1] != bus_a.jraddr);
            q[q.size()-1] = t_pc4;
          end
        end
        if (t_miss) begin
          if (m_cnt_a < 65535) m_cnt_a++;
          if (m_cnt_b < 3) m_cnt_b++;
        end
        m_pc = t_nxt;
      end
      m_miss = t_miss;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("pcaddr", bus_a.pcaddr, m_pc);
      chk("nxt_pc", bus_a.nxt_pc, exp_nxt());
      chk("ras_top", bus_a.ras_top, exp_top());
      chk("ras_empty", 32'(bus_a.ras_empty), 32'(q.size() == 0));
      chk("ras_miss", 32'(bus_a.ras_miss), 32'(m_miss));
      chk("miss_cnt", 32'(bus_a.miss_cnt), m_cnt_a);
      chk("miss_cnt_w2", 32'(bus_b.miss_cnt), m_cnt_b);
      chk("pcaddr_b", bus_b.pcaddr, m_pc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic ih, input logic st, input logic br, input word_t bi,
                       input logic jp, input logic [ADDR_W-1:0] ji, input logic jr,
                       input word_t ja, input logic lk);
    bus_a.ihit   = ih;
    bus_a.stall  = st;
    bus_a.Branch = br;
    bus_a.bimm   = bi;
    bus_a.Jump   = jp;
    bus_a.jimm   = ji;
    bus_a.JR     = jr;
    bus_a.jraddr = ja;
    bus_a.link   = lk;
  endtask

  task automatic cyc(input logic ih, input logic st, input logic br, input word_t bi,
                     input logic jp, input logic [ADDR_W-1:0] ji, input logic jr,
                     input word_t ja, input logic lk);
    drive(ih, st, br, bi, jp, ji, jr, ja, lk);
    @(posedge CLK);
    #2;
  endtask

  initial begin
    word_t r;
    word_t e;
    drive(0, 0, 0, 0, 0, 26'h0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    chk_en = 1'b1;
    chk("rst_pcaddr", bus_a.pcaddr, 32'h0);
    chk("rst_empty", 32'(bus_a.ras_empty), 32'h1);
    chk("rst_top", bus_a.ras_top, 32'h0);
    chk("rst_cnt", 32'(bus_a.miss_cnt), 32'h0);

    for (int i = 1; i <= 3; i++) begin
      cyc(1, 0, 0, 0, 0, 26'h0, 0, 0, 0);
      chk("seq_pc", bus_a.pcaddr, 32'(i * 4));
    end
    cyc(1, 0, 0, 0, 0, 26'h0, 1, 32'h40, 0);
    chk("jr_pc", bus_a.pcaddr, 32'h40);
    chk("emptypop_miss", 32'(bus_a.ras_miss), 32'h1);
    chk("emptypop_cnt", 32'(bus_a.miss_cnt), 32'h1);

    cyc(1, 1, 0, 0, 0, 26'h0, 0, 0, 0);
    chk("stall_hold", bus_a.pcaddr, 32'h40);
    RST = 1'b1;
    #1;
    chk("async_rst_pc", bus_a.pcaddr, 32'h0);
    chk("async_rst_cnt", 32'(bus_a.miss_cnt), 32'h0);
    #4;
    RST = 1'b0;

    cyc(1, 1, 0, 0, 0, 26'h0, 0, 0, 0);
    chk("stall_pc", bus_a.pcaddr, 32'h0);
    cyc(1, 0, 0, 0, 1, 26'h40, 0, 0, 0);
    chk("jump_pc", bus_a.pcaddr, 32'h100);
    cyc(1, 0, 1, 32'hFFFF_FFFE, 0, 26'h0, 0, 0, 0);
    chk("branch_neg", bus_a.pcaddr, 32'hFC);
    cyc(1, 0, 1, 32'h0000_0010, 1, 26'h40, 0, 0, 0);
    chk("jump_wins", bus_a.pcaddr, 32'h100);

    cyc(1, 0, 0, 0, 1, 26'h80, 0, 0, 1);
    chk("jal_pc", bus_a.pcaddr, 32'h200);
    chk("jal_top", bus_a.ras_top, 32'h104);
    cyc(1, 0, 0, 0, 0, 26'h0, 1, 32'h104, 0);
    chk("ret_pc", bus_a.pcaddr, 32'h104);
    chk("ret_hit", 32'(bus_a.ras_miss), 32'h0);
    chk("ret_empty", 32'(bus_a.ras_empty), 32'h1);

    cyc(1, 0, 0, 0, 1, 26'h100, 0, 0, 1);
    chk("jal2_top", bus_a.ras_top, 32'h108);
    cyc(1, 0, 0, 0, 0, 26'h0, 1, 32'h200, 0);
    chk("mis_pc", bus_a.pcaddr, 32'h200);
    chk("mis_pulse", 32'(bus_a.ras_miss), 32'h1);
    chk("mis_cnt1", 32'(bus_a.miss_cnt), 32'h1);
    cyc(1, 0, 0, 0, 0, 26'h0, 0, 0, 0);
    chk("mis_pulse_end", 32'(bus_a.ras_miss), 32'h0);
    cyc(1, 0, 0, 0, 0, 26'h0, 1, 32'h400, 0);
    chk("jr400_pc", bus_a.pcaddr, 32'h400);
    chk("mis_cnt2", 32'(bus_a.miss_cnt), 32'h2);
    chk("still_empty", 32'(bus_a.ras_empty), 32'h1);

    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 26'h0, 0, 0, 1);
    chk("wrap_top", bus_a.ras_top, 32'h414);
    for (int k = 0; k < 4; k++) begin
      e = 32'h414 - 32'(4 * k);
      chk("wrap_top_k", bus_a.ras_top, e);
      cyc(1, 0, 0, 0, 0, 26'h0, 1, e, 0);
      chk("wrap_pop_hit", 32'(bus_a.ras_miss), 32'h0);
    end
    chk("wrap_empty", 32'(bus_a.ras_empty), 32'h1);
    cyc(1, 0, 0, 0, 0, 26'h0, 1, 32'h500, 0);
    chk("wrap_lost", 32'(bus_a.ras_miss), 32'h1);
    chk("mis_cnt3", 32'(bus_a.miss_cnt), 32'h3);

    cyc(1, 0, 0, 0, 0, 26'h0, 1, 32'h500, 0);
    cyc(1, 0, 0, 0, 0, 26'h0, 1, 32'h500, 0);
    chk("sat_w2", 32'(bus_b.miss_cnt), 32'h3);
    chk("cnt_w16", 32'(bus_a.miss_cnt), 32'h5);

    cyc(1, 0, 0, 0, 0, 26'h0, 0, 0, 1);
    chk("jalr_pre_top", bus_a.ras_top, 32'h504);
    cyc(1, 0, 0, 0, 0, 26'h0, 1, 32'h800, 1);
    chk("jalr_pc", bus_a.pcaddr, 32'h800);
    chk("jalr_top", bus_a.ras_top, 32'h508);
    chk("jalr_nonempty", 32'(bus_a.ras_empty), 32'h0);
    chk("jalr_miss", 32'(bus_a.ras_miss), 32'h1);
    cyc(1, 0, 0, 0, 0, 26'h0, 1, 32'h508, 0);
    chk("jalr_ret_hit", 32'(bus_a.ras_miss), 32'h0);
    chk("jalr_ret_empty", 32'(bus_a.ras_empty), 32'h1);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      drive(($urandom % 10) < 8, ($urandom % 5) == 0, ($urandom % 4) == 0,
            {{24{r[7]}}, r[7:0]}, ($urandom % 4) == 0, 26'($urandom),
            ($urandom % 4) == 0,
            (($urandom % 2) == 0) ? exp_top() : {$urandom_range(0, 32'h3FFF), 2'b00},
            ($urandom % 4) == 0);
      if (($urandom % 250) == 0) RST = 1'b1;
      @(posedge CLK);
      #2;
      RST = 1'b0;
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
